piso_shift_register: RTL and testbench

PISO_SHIFT_REGISTER -- requirements
Module: piso_shift_register

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_bit_counter.sv | 35 +++
 rtl/piso_shift_register.sv | 138 +++++++++++++
 tb/tb_piso_shift_register.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in/serial-out shifter.
//   state_t        - FSM state encoding (ST_PARITY exists only with SR_PARITY_EN)
//   DEFAULT_WIDTH  - default parallel word width
// Optional feature macro: SR_PARITY_EN (appends an even-parity bit per frame).
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

`ifdef SR_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts data bits consumed within one frame.
//   i_CLK   - clock, rising edge
//   i_RST   - synchronous active-high reset (count -> 0)
//   i_Clear - synchronous clear at frame start (count -> 0)
//   i_En    - advance the count by one
//   o_Tc    - terminal count: the last data bit (bit 0) is being presented
// Counter is $clog2(WIDTH+1) bits and saturates at WIDTH, so it never wraps
// inside a frame.
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_Clear,
  input  logic i_En,
  output logic o_Tc
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] TC_VAL  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_VAL = CW'(WIDTH);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_CLK) begin
    if (i_RST || i_Clear) begin
      r_count <= '0;
    end else if (i_En && (r_count != MAX_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Tc = (r_count == TC_VAL);

endmodule

// File: rtl/piso_shift_register.sv
// piso_shift_register: serializes a WIDTH-bit word MSB first on o_SO.
//   i_CLK   - clock, rising edge
//   i_RST   - synchronous active-high reset, priority over everything
//   i_En    - shift enable; each enabled edge advances the stream one bit
//   i_VALID - word offered on i_DATA (accepted only when o_READY=1)
//   i_DATA  - parallel word
//   o_READY - idle, can accept a word
//   o_SO    - serial data out (0 while idle)
//   o_BUSY  - a frame is being presented
//   o_LAST  - o_SO carries the final bit of the frame
// Optional feature macro: SR_PARITY_EN (even-parity bit after bit 0).
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_En,
  input  logic             i_VALID,
  input  logic [WIDTH-1:0] i_DATA,
  output logic             o_READY,
  output logic             o_SO,
  output logic             o_BUSY,
  output logic             o_LAST
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shift;
  logic             w_accept;
  logic             w_shift_en;
  logic             w_tc;

  assign w_accept   = (r_state == ST_IDLE) && i_VALID;
  assign w_shift_en = (r_state == ST_SHIFT) && i_En;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_Clear(w_accept),
    .i_En   (w_shift_en),
    .o_Tc   (w_tc)
  );

  // Shift toward the MSB so the outgoing bit is always r_shift[WIDTH-1];
  // a receiver shifting toward its MSB rebuilds the word in order.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= i_DATA;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SR_PARITY_EN
  // Parity is captured at load; the shift register is drained by then.
  logic r_parity;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^i_DATA;
    end
  end
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_VALID) begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_En && w_tc) begin
`ifdef SR_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_IDLE;
`endif
        end
      end
`ifdef SR_PARITY_EN
      ST_PARITY: begin
        if (i_En) begin
          w_next_state = ST_IDLE;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_READY = 1'b0;
    o_BUSY  = 1'b0;
    o_SO    = 1'b0;
    o_LAST  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_READY = 1'b1;
      end
      ST_SHIFT: begin
        o_BUSY = 1'b1;
        o_SO   = r_shift[WIDTH-1];
`ifndef SR_PARITY_EN
        o_LAST = w_tc;
`endif
      end
`ifdef SR_PARITY_EN
      ST_PARITY: begin
        o_BUSY = 1'b1;
        o_SO   = r_parity;
        o_LAST = 1'b1;
      end
`endif
      default: begin
        o_READY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_register.sv
module tb_piso_shift_register;

  logic       i_CLK;
  logic       i_RST;
  logic       i_En;
  logic       i_VALID;
  logic [3:0] i_DATA;
  logic       o_READY;
  logic       o_SO;
  logic       o_BUSY;
  logic       o_LAST;

  int n_pass;
  int n_checks;

`ifdef SR_PARITY_EN
  localparam logic L0 = 1'b0;
`else
  localparam logic L0 = 1'b1;
`endif

  piso_shift_register #(
    .WIDTH(4)
  ) dut (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_En   (i_En),
    .i_VALID(i_VALID),
    .i_DATA (i_DATA),
    .o_READY(o_READY),
    .o_SO   (o_SO),
    .o_BUSY (o_BUSY),
    .o_LAST (o_LAST)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Serial-in receiver: shifts toward the MSB, captures o_SO into bit 0.
  logic [3:0] r_si;
  always @(posedge i_CLK) begin
    if (i_En && o_BUSY) begin
      r_si <= {r_si[2:0], o_SO};
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic so, input logic busy,
                            input logic last, input logic ready);
    chk({tag, ".so"},    {3'b0, o_SO},    {3'b0, so});
    chk({tag, ".busy"},  {3'b0, o_BUSY},  {3'b0, busy});
    chk({tag, ".last"},  {3'b0, o_LAST},  {3'b0, last});
    chk({tag, ".ready"}, {3'b0, o_READY}, {3'b0, ready});
  endtask

  // Parity bit (if built in) followed by the return to idle.
  task automatic finish_frame(input string tag, input logic par);
`ifdef SR_PARITY_EN
    tick();
    expect_out({tag, ".par"}, par, 1'b1, 1'b1, 1'b0);
`else
    if (par === 1'bx) $display("unreachable");
`endif
    tick();
    expect_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    r_si     = 4'b0;
    i_RST    = 1'b1;
    i_En     = 1'b0;
    i_VALID  = 1'b0;
    i_DATA   = 4'b0;

    // Reset held two cycles.
    tick();
    tick();
    expect_out("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    i_RST = 1'b0;

    // Basic frame 1011 with enable held.
    i_VALID = 1'b1;
    i_DATA  = 4'b1011;
    i_En    = 1'b1;
    tick();
    i_VALID = 1'b0;
    expect_out("basic.b3", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("basic.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("basic.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("basic.b0", 1'b1, 1'b1, L0, 1'b0);
`ifndef SR_PARITY_EN
    tick();
    chk("loopback", r_si, 4'b1011);
    expect_out("basic.idle", 1'b0, 1'b0, 1'b0, 1'b1);
`else
    finish_frame("basic", 1'b1);
`endif

    // Enable gap after the second bit of 1100.
    i_VALID = 1'b1;
    i_DATA  = 4'b1100;
    tick();
    i_VALID = 1'b0;
    expect_out("gap.b3", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("gap.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    i_En = 1'b0;
    tick();
    expect_out("gap.hold1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("gap.hold2", 1'b1, 1'b1, 1'b0, 1'b0);
    i_En = 1'b1;
    tick();
    expect_out("gap.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("gap.b0", 1'b0, 1'b1, L0, 1'b0);
    finish_frame("gap", 1'b0);

    // A new word offered mid-frame is ignored until idle.
    i_VALID = 1'b1;
    i_DATA  = 4'b1011;
    tick();
    expect_out("vb.b3", 1'b1, 1'b1, 1'b0, 1'b0);
    i_DATA = 4'b0101;
    tick();
    expect_out("vb.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("vb.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("vb.b0", 1'b1, 1'b1, L0, 1'b0);
`ifdef SR_PARITY_EN
    tick();
    expect_out("vb.par", 1'b1, 1'b1, 1'b1, 1'b0);
`endif
    tick();
    expect_out("vb.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    // Still valid in idle: 0101 is accepted now.
    tick();
    i_VALID = 1'b0;
    expect_out("w2.b3", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("w2.b2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("w2.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("w2.b0", 1'b1, 1'b1, L0, 1'b0);
    finish_frame("w2", 1'b0);

    // Reset after two bits of 1011, with valid/enable also high.
    i_VALID = 1'b1;
    i_DATA  = 4'b1011;
    tick();
    i_VALID = 1'b0;
    expect_out("rm.b3", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rm.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    i_RST   = 1'b1;
    i_VALID = 1'b1;
    tick();
    expect_out("rm.rst", 1'b0, 1'b0, 1'b0, 1'b1);
    i_RST  = 1'b0;
    i_DATA = 4'b0110;
    tick();
    i_VALID = 1'b0;
    expect_out("rm.n3", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rm.n2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rm.n1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("rm.n0", 1'b0, 1'b1, L0, 1'b0);
`ifndef SR_PARITY_EN
    tick();
    chk("loopback2", r_si, 4'b0110);
    expect_out("rm.idle", 1'b0, 1'b0, 1'b0, 1'b1);
`else
    finish_frame("rm", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
